// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - 1 Hz sec/min stopwatch controller with start/stop and lap/reset buttons
// Optional macro STOPWATCH_BTN_SYNC_EN: synchronize and edge-detect asynchronous level buttons.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 6000000,
   parameter int SEC_MAX  = 59,
   parameter int MIN_MAX  = 99
) (
   input  logic       clk_6m,
   input  logic       xrst,
   input  logic       btn_ss,
   input  logic       btn_lr,
   output logic [5:0] disp_sec,
   output logic [6:0] disp_min,
   output logic       running,
   output logic       lap_active,
   output logic       tick
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV);
   localparam logic [5:0]    SEC_LAST = 6'(SEC_MAX);
   localparam logic [6:0]    MIN_LAST = 7'(MIN_MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_LAP  = 2'd2,
      S_STOP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q;
   logic [5:0]      sec_q, frz_sec_q;
   logic [6:0]      min_q, frz_min_q;
   logic            tick_q;
   logic            ss_evt, lr_evt;
   logic            do_latch, do_clear;
   logic            counting, wrap;

`ifdef STOPWATCH_BTN_SYNC_EN
   // Two synchronizer flops, then a third flop for rising-edge detection.
   logic [2:0] ss_sync, lr_sync;

   always_ff @(posedge clk_6m or negedge xrst) begin
      if (!xrst) begin
         ss_sync <= 3'b000;
         lr_sync <= 3'b000;
      end else begin
         ss_sync <= {ss_sync[1:0], btn_ss};
         lr_sync <= {lr_sync[1:0], btn_lr};
      end
   end

   assign ss_evt = ss_sync[1] & ~ss_sync[2];
   assign lr_evt = lr_sync[1] & ~lr_sync[2];
`else
   assign ss_evt = btn_ss;
   assign lr_evt = btn_lr;
`endif

   always_ff @(posedge clk_6m or negedge xrst) begin
      if (!xrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      do_latch = 1'b0;
      do_clear = 1'b0;
      case (state_q)
         S_IDLE: if (ss_evt) state_d = S_RUN;
         S_RUN: begin
            if (ss_evt) state_d = S_STOP;
            else if (lr_evt) begin
               state_d  = S_LAP;
               do_latch = 1'b1;
            end
         end
         S_LAP: begin
            if (ss_evt)      state_d = S_STOP;
            else if (lr_evt) state_d = S_RUN;
         end
         S_STOP: begin
            if (ss_evt) state_d = S_RUN;
            else if (lr_evt) begin
               state_d  = S_IDLE;
               do_clear = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counting depends on the current state, so a tick coinciding with a stop still lands.
   assign counting = (state_q == S_RUN) || (state_q == S_LAP);
   assign wrap     = counting && (presc_q == PRE_LAST);

   always_ff @(posedge clk_6m or negedge xrst) begin
      if (!xrst) begin
         presc_q <= PRE_ONE;
         sec_q   <= 6'd0;
         min_q   <= 7'd0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= wrap;
         if (do_clear || state_q == S_IDLE) presc_q <= PRE_ONE;
         else if (counting)                 presc_q <= wrap ? PRE_ONE : presc_q + PRE_ONE;
         if (do_clear) begin
            sec_q <= 6'd0;
            min_q <= 7'd0;
         end else if (wrap) begin
            if (sec_q != SEC_LAST) begin
               sec_q <= sec_q + 6'd1;
            end else begin
               sec_q <= 6'd0;
               min_q <= (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_6m or negedge xrst) begin
      if (!xrst) begin
         frz_sec_q <= 6'd0;
         frz_min_q <= 7'd0;
      end else if (do_latch) begin
         frz_sec_q <= sec_q;
         frz_min_q <= min_q;
      end
   end

   assign running    = counting;
   assign lap_active = (state_q == S_LAP);
   assign tick       = tick_q;
   assign disp_sec   = lap_active ? frz_sec_q : sec_q;
   assign disp_min   = lap_active ? frz_min_q : min_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed vector bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic xrst = 1'b0;
   logic ss_a = 1'b0, lr_a = 1'b0, ss_b = 1'b0, lr_b = 1'b0;
   logic [5:0] sec_a, sec_b;
   logic [6:0] min_a, min_b;
   logic run_a, lap_a, tk_a, run_b, lap_b, tk_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       ss;
      logic       lr;
      logic       run;
      logic       lap;
      logic       tk;
      logic [5:0] sec;
      logic [6:0] min;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(4)) dut_a (
      .clk_6m(clk), .xrst(xrst), .btn_ss(ss_a), .btn_lr(lr_a),
      .disp_sec(sec_a), .disp_min(min_a), .running(run_a),
      .lap_active(lap_a), .tick(tk_a)
   );

   stopwatch_ctrl #(.TICK_DIV(2), .SEC_MAX(2), .MIN_MAX(1)) dut_b (
      .clk_6m(clk), .xrst(xrst), .btn_ss(ss_b), .btn_lr(lr_b),
      .disp_sec(sec_b), .disp_min(min_b), .running(run_b),
      .lap_active(lap_b), .tick(tk_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic ss, input logic lr, input logic run, input logic lap,
                      input logic tk, input int sec, input int min);
      vec_t v;
      v.ss = ss; v.lr = lr; v.run = run; v.lap = lap; v.tk = tk;
      v.sec = 6'(sec); v.min = 7'(min);
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] pack_a();
      return {16'd0, run_a, lap_a, tk_a, sec_a, min_a};
   endfunction

   function automatic logic [31:0] pack_v(input vec_t v);
      return {16'd0, v.run, v.lap, v.tk, v.sec, v.min};
   endfunction

   initial begin
      int exp_sec[6] = '{1, 2, 0, 1, 2, 0};
      int exp_min[6] = '{0, 0, 1, 1, 1, 0};

      // ss lr | run lap tick sec min
      add(0,0, 0,0,0, 0,0);
      add(0,1, 0,0,0, 0,0);
      add(1,0, 1,0,0, 0,0);
      add(0,0, 1,0,0, 0,0); add(0,0, 1,0,0, 0,0); add(0,0, 1,0,0, 0,0);
      add(0,0, 1,0,1, 1,0);
      add(0,0, 1,0,0, 1,0); add(0,0, 1,0,0, 1,0); add(0,0, 1,0,0, 1,0);
      add(0,0, 1,0,1, 2,0);
      add(0,0, 1,0,0, 2,0);
      add(1,0, 0,0,0, 2,0);
      add(0,0, 0,0,0, 2,0); add(0,0, 0,0,0, 2,0);
      add(1,0, 1,0,0, 2,0);
      add(0,0, 1,0,0, 2,0);
      add(0,0, 1,0,1, 3,0);
      add(0,1, 1,1,0, 3,0);
      add(0,0, 1,1,0, 3,0); add(0,0, 1,1,0, 3,0);
      add(0,0, 1,1,1, 3,0);
      add(0,0, 1,1,0, 3,0); add(0,0, 1,1,0, 3,0); add(0,0, 1,1,0, 3,0);
      add(0,0, 1,1,1, 3,0);
      add(0,0, 1,1,0, 3,0); add(0,0, 1,1,0, 3,0); add(0,0, 1,1,0, 3,0);
      add(0,0, 1,1,1, 3,0);
      add(0,1, 1,0,0, 6,0);
      add(1,1, 0,0,0, 6,0);
      add(0,1, 0,0,0, 0,0);
      add(1,1, 1,0,0, 0,0);
      add(0,0, 1,0,0, 0,0); add(0,0, 1,0,0, 0,0); add(0,0, 1,0,0, 0,0);
      add(0,0, 1,0,1, 1,0);
      add(0,1, 1,1,0, 1,0);
      add(0,0, 1,1,0, 1,0); add(0,0, 1,1,0, 1,0);
      add(0,0, 1,1,1, 1,0);
      add(1,0, 0,0,0, 2,0);
      add(1,0, 1,0,0, 2,0);
      add(0,1, 1,1,0, 2,0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_a", pack_a(), 32'd0);
      check("reset_b", {16'd0, run_b, lap_b, tk_b, sec_b, min_b}, 32'd0);
      @(negedge clk);
      xrst = 1'b1;

`ifndef STOPWATCH_BTN_SYNC_EN
      foreach (vecs[i]) begin
         @(negedge clk);
         ss_a = vecs[i].ss;
         lr_a = vecs[i].lr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), pack_a(), pack_v(vecs[i]));
      end
      @(negedge clk);
      ss_a = 1'b0;
      lr_a = 1'b0;

      // Asynchronous reset while in LAP, between edges.
      @(posedge clk);
      #2;
      xrst = 1'b0;
      #1;
      check("async_rst_out", pack_a(), 32'd0);
      @(negedge clk);
      xrst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_idle", pack_a(), 32'd0);

      // Wrap on the small instance.
      @(negedge clk);
      ss_b = 1'b1;
      @(posedge clk);
      #1;
      check("wrap_start_run", {31'd0, run_b}, 32'd1);
      @(negedge clk);
      ss_b = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("wrap_gap%0d", k), {31'd0, tk_b}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("wrap_tick%0d", k), {31'd0, tk_b}, 32'd1);
         check($sformatf("wrap_val%0d", k), {19'd0, min_b, sec_b},
               {19'd0, 7'(exp_min[k]), 6'(exp_sec[k])});
      end
`else
      @(negedge clk);
      ss_a = 1'b1;
      @(posedge clk); #1; check("sync_e0", {31'd0, run_a}, 32'd0);
      @(posedge clk); #1; check("sync_e1", {31'd0, run_a}, 32'd0);
      @(posedge clk); #1; check("sync_e2", {31'd0, run_a}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      check("sync_held", {31'd0, run_a}, 32'd1);
      @(negedge clk);
      ss_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("sync_release", {31'd0, run_a}, 32'd1);
      #2;
      xrst = 1'b0;
      #1;
      check("async_rst_out", pack_a(), 32'd0);
      @(negedge clk);
      xrst = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences a 1 Hz seconds/minutes count from the 6 MHz system clock under two-button user control: start/stop, and lap/reset.
- Contains the prescaler, the live time registers, the display-freeze (lap) register and the control FSM.
- Sits between the front-panel button logic and the 7-segment display driver.

Parameters:
- TICK_DIV, 6000000: clk_6m cycles per one-second tick. Must be >= 2.
- SEC_MAX, 59: last seconds value before wrap.
- MIN_MAX, 99: last minutes value before wrap.

Ports:
- clk_6m  in  1  system clock, 6 MHz.
- xrst  in  1  reset, asynchronous, active-low.
- btn_ss  in  1  start/stop request.
- btn_lr  in  1  lap/reset request.
- disp_sec  out  6  seconds shown on display, 0..SEC_MAX.
- disp_min  out  7  minutes shown on display, 0..MIN_MAX.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP (display frozen).
- tick  out  1  one-cycle pulse, high in the same cycle the live seconds register shows its new value.

Behaviour:
- Reset (xrst low, asynchronous):
  - FSM = IDLE.
  - prescaler = 1.
  - live sec/min = 0; frozen sec/min = 0.
  - All outputs = 0.
- FSM states: IDLE, RUN, LAP, STOP. State is encoded in 2 bits; unused codes go to IDLE.
- Press events: ss = qualified btn_ss press; lr = qualified btn_lr press.
- Simultaneous presses: ss has priority; lr is ignored in that cycle.
- Transitions:
  - IDLE: on ss, go to RUN with prescaler = 1. lr has no effect.
  - RUN: on ss, go to STOP. On lr, go to LAP and latch the live sec/min into the frozen registers in that cycle.
  - LAP: on ss, go to STOP and release the freeze. On lr, go to RUN and release the freeze.
  - STOP: on ss, go to RUN; the prescaler resumes from its held value, with no restart. On lr, go to IDLE and clear the live sec/min and prescaler to 0/0/1.
- Prescaler:
  - Width is $clog2(TICK_DIV+1) bits.
  - It advances only when the current state is RUN or LAP, and holds otherwise.
  - It counts 1..TICK_DIV.
  - At TICK_DIV it reloads to 1 and increments the time on the next edge, with tick registered high for that one cycle.
- Increment rules are evaluated on the current state, so a tick coincident with a stopping ss still counts:
  - If sec < SEC_MAX: sec + 1.
  - Else: sec = 0; min + 1.
  - If min = MIN_MAX and sec = SEC_MAX: both wrap to 0, with no saturation and no flag.
- Display outputs:
  - disp_sec/disp_min = frozen registers while in LAP, otherwise the live registers.
  - All outputs are registered or derived from registers only; there is no combinational path from the buttons to the outputs.
- Reset mid-count: all state is lost immediately. After release, the block waits in IDLE.
- Presses on consecutive cycles are each processed in order.

Optional Feature:
- Macro: STOPWATCH_BTN_SYNC_EN.
- Defined:
  - btn_ss/btn_lr are asynchronous, level buttons.
  - Each passes through a 2-flop synchronizer and a rising-edge detector, so one press = one event, 3 cycles after the input rises.
  - A held button generates no further events.
- Undefined:
  - btn_ss/btn_lr must be synchronous to clk_6m.
  - Every cycle a button is high is a press event, with 0 added latency.

Test Plan:
1. Reset and first run (TICK_DIV=4, macro off): xrst low -> all outputs 0. Release, pulse btn_ss -> running=1; tick every 4 cycles; disp_sec steps 0,1,2.
2. Stop/resume (TICK_DIV=4):
   - btn_ss after 2 prescaler cycles -> running=0 and disp held.
   - btn_ss again -> next tick arrives after 2 more cycles, not 4.
   - btn_lr in STOP -> disp 0:00, state IDLE.
3. Lap freeze (TICK_DIV=4): in RUN at sec=3, btn_lr -> lap_active=1 and disp_sec stays 3 while tick continues. After 3 ticks, btn_lr -> disp_sec=6, lap_active=0.
4. Wrap (SEC_MAX=2, MIN_MAX=1, TICK_DIV=2): run for 6 ticks -> sequence 0:00,0:01,0:02,1:00,1:01,1:02,0:00.
5. Simultaneous presses: btn_ss and btn_lr high together in RUN -> STOP, lap_active stays 0; in IDLE -> RUN.
6. Async reset mid-LAP: drop xrst between clock edges -> outputs 0 immediately, without waiting for an edge. Macro on: hold btn_ss high 10 cycles -> exactly one event, running=1 three cycles after the rise.
